tbm_port_arbiter: RTL and testbench
===================================

// Module: tbm_port_arbiter
// PURPOSE
//  Shares the single TBM port (cs/we/address/256-bit data) between two burst requesters:
//  r0 = xfer_buffer (host <-> TBM staging), r1 = backend media engine. Round-robin arbitration,
//  one whole burst per grant, row address auto-increment. Sits between the requesters and tbm.
// PARAMETERS
//  ADDR_W   32   TBM row address width
//  DATA_W   256  TBM row width
//  LEN_W    4    burst length field; len==0 means 2**LEN_W (16) beats
// PORTS  (rN_* exists for N = 0 and N = 1)
//  clock_fpga   in   1       single clock; all logic on posedge
//  reset_n      in   1       asynchronous, active-low reset
//  rN_req       in   1       burst request; held high until rN_grant
//  rN_write     in   1       1 = write burst, 0 = read burst; sampled with rN_req
//  rN_addr      in   ADDR_W  first row address; sampled with rN_req
//  rN_len       in   LEN_W   beat count (0 -> 16)
//  rN_wdata     in   DATA_W  write data for the current beat
//  rN_grant     out  1       high for the whole burst owned by rN
//  rN_wack      out  1       write beat accepted this cycle; present next rN_wdata next cycle
//  rN_rvalid    out  1       rd_data holds a valid read beat for rN
//  rN_done      out  1       one-cycle pulse, burst complete
//  rd_data      out  DATA_W  read data, shared by both requesters
//  tbm_cs       out  1       TBM chip select
//  tbm_we       out  1       TBM write enable
//  tbm_addr     out  ADDR_W  TBM row address
//  tbm_data     inout DATA_W driven only while tbm_cs & tbm_we; else Z
// BEHAVIOUR
//  Reset (reset_n low, any time, including mid-burst)
//  - State -> IDLE. All outputs 0, tbm_data Z, last_owner = 1 so r0 wins the first tie.
//  - An in-flight burst is abandoned; no done pulse.
//  FSM: IDLE -> BURST -> (DRAIN for reads) -> DONE -> IDLE
//  - IDLE: if any rN_req, pick a winner. Latch write, addr and len (0 -> 16). Clear beat_cnt.
//    Go to BURST; rN_grant rises on the next cycle.
//  - Arbitration: one requester -> it wins. Both -> the one that is not last_owner wins.
//    last_owner updates at the grant.
//  - BURST, one beat per cycle, no stalls:
//    tbm_cs = 1, tbm_we = write, tbm_addr = base + beat_cnt (mod 2**ADDR_W, wraps silently).
//  - BURST write: tbm_data = rN_wdata and rN_wack = 1 in the same cycle.
//  - BURST read: the TBM returns the row one cycle after cs. rd_data is registered from tbm_data
//    and rN_rvalid is asserted the cycle after that TBM return.
//  - BURST exit: after len beats, writes go to DONE and reads go to DRAIN.
//  - DRAIN: lasts until the final rvalid is emitted, then DONE. tbm_cs = 0.
//  - DONE: rN_done = 1 for one cycle, rN_grant stays high this cycle, then IDLE with grant low.
//  - Turnaround: minimum one IDLE cycle between bursts.
//  Latency
//  - Write: rN_req at cycle T -> grant and first cs at T+1 -> done at T+1+len.
//  - Read: first rvalid at T+3, done at T+3+len.
//  Rules
//  - rN_req, rN_addr and rN_len changing during an owned burst are ignored.
//  - A request dropped before grant is never served.
//  - A request reasserted in DONE competes at the next IDLE, where the other requester has priority.
//  - cs is never asserted outside BURST. Exactly one rN_grant at a time.
// TESTING
//  - Write: r0 write, addr 0x100, len 4, wdata = beat index.
//    -> tbm rows 0x100..0x103 = 0..3, 4 wacks, r0_done at T+5.
//  - Tie: r0 and r1 request the same cycle after reset.
//    -> r0 served first, then r1, with one IDLE cycle between; r1 never starved.
//  - Read: r1 read, addr 0x100, len 4.
//    -> 4 consecutive r1_rvalid with rd_data 0..3; done one cycle after the last rvalid.
//  - Max burst and wrap: len 0, addr 0xFFFF_FFF8.
//    -> 16 beats, addresses wrap to 0x0000_0007, done after beat 16.
//  - Fairness: r0 re-requests continuously while r1 waits.
//    -> grants alternate r0, r1, r0, r1.
//  - Reset: reset_n low at beat 2 of an 8-beat write.
//    -> all outputs 0 immediately, no done; a fresh request after release is served normally.

Source files
------------

// File: rtl/tbm_port_arbiter.sv
// tbm_port_arbiter
// Shares the single TBM row port between two burst requesters:
//   r0 = xfer_buffer (host <-> TBM staging), r1 = backend media engine.
// Round-robin arbitration, one whole burst per grant, one beat per cycle,
// row address auto-increment with silent wrap.
//
// Burst timeline (request sampled in IDLE at cycle T):
//   write : grant + cs at T+1 .. T+len, done at T+1+len
//   read  : cs at T+1 .. T+len, TBM returns row one cycle after cs,
//           rd_data/rvalid one cycle after that (T+3 .. T+2+len),
//           done at T+3+len
// len == 0 encodes the maximum burst of 2**LEN_W beats.
module tbm_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256,
    parameter int LEN_W  = 4
) (
    input  logic              clock_fpga,
    input  logic              reset_n,

    // requester 0 : xfer_buffer
    input  logic              r0_req,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [LEN_W-1:0]  r0_len,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_grant,
    output logic              r0_wack,
    output logic              r0_rvalid,
    output logic              r0_done,

    // requester 1 : backend media engine
    input  logic              r1_req,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [LEN_W-1:0]  r1_len,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_grant,
    output logic              r1_wack,
    output logic              r1_rvalid,
    output logic              r1_done,

    // shared read data
    output logic [DATA_W-1:0] rd_data,

    // TBM port
    output logic              tbm_cs,
    output logic              tbm_we,
    output logic [ADDR_W-1:0] tbm_addr,
    inout  wire  [DATA_W-1:0] tbm_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t              r_state;
    logic                r_owner;       // requester owning the current burst
    logic                r_last_owner;  // owner of the most recent grant
    logic [LEN_W-1:0]    r_beat;        // beat index within the burst
    logic [LEN_W-1:0]    r_last_beat;   // len-1; len==0 wraps to the max burst
    logic                r_cs;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_grant;
    logic [1:0]          r_wack;
    logic [1:0]          r_rvalid;
    logic [1:0]          r_done;
    logic                r_rd_pend;     // TBM is returning a row this cycle
    logic [DATA_W-1:0]   r_rd_data;

    // ------------------------------------------------------------------
    // Arbitration and data muxing
    // ------------------------------------------------------------------
    logic                w_win;
    logic [1:0]          w_win_oh;
    logic                w_win_write;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [LEN_W-1:0]    w_win_len;
    logic [DATA_W-1:0]   w_wdata;

    // Round-robin pick: a lone requester wins, a tie goes to the one that did not own last.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves a latch.
        w_win = 1'b0;
        if (r0_req && r1_req) begin
            w_win = ~r_last_owner;
        end else if (r1_req) begin
            w_win = 1'b1;
        end
        w_win_oh    = w_win ? 2'b10    : 2'b01;
        w_win_write = w_win ? r1_write : r0_write;
        w_win_addr  = w_win ? r1_addr  : r0_addr;
        w_win_len   = w_win ? r1_len   : r0_len;
    end

    // Write data comes straight from the owner in the beat it is accepted.
    assign w_wdata  = r_owner ? r1_wdata : r0_wdata;

    // Drive the shared row bus only during write beats; the TBM owns it otherwise.
    assign tbm_data = (r_cs && r_we) ? w_wdata : {DATA_W{1'bz}};

    // ------------------------------------------------------------------
    // Burst FSM with registered outputs and read-return pipeline.
    // ------------------------------------------------------------------
    // Sequence IDLE -> BURST -> (DRAIN for reads) -> DONE -> IDLE, and capture read returns.
    always_ff @(posedge clock_fpga or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            // r1 counts as the previous owner so r0 takes the first tie.
            r_last_owner <= 1'b1;
            r_beat       <= '0;
            r_last_beat  <= '0;
            r_cs         <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_grant      <= '0;
            r_wack       <= '0;
            r_rvalid     <= '0;
            r_done       <= '0;
            r_rd_pend    <= 1'b0;
            // NOTE: the wide read-data register is reset too, because every output must read 0 while in reset.
            r_rd_data    <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge state.
            r_done    <= '0;
            r_rvalid  <= '0;
            // The TBM answers one cycle after a read chip select.
            r_rd_pend <= r_cs && !r_we;
            if (r_rd_pend) begin
                r_rd_data         <= tbm_data;
                r_rvalid[r_owner] <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (r0_req || r1_req) begin
                        r_owner      <= w_win;
                        r_last_owner <= w_win;
                        r_beat       <= '0;
                        r_last_beat  <= w_win_len - 1'b1;
                        r_cs         <= 1'b1;
                        r_we         <= w_win_write;
                        r_addr       <= w_win_addr;
                        r_grant      <= w_win_oh;
                        r_wack       <= w_win_write ? w_win_oh : 2'b00;
                        r_state      <= S_BURST;
                    end
                end

                S_BURST: begin
                    if (r_beat == r_last_beat) begin
                        r_cs   <= 1'b0;
                        r_we   <= 1'b0;
                        r_addr <= '0;
                        r_wack <= '0;
                        if (r_we) begin
                            r_done[r_owner] <= 1'b1;
                            r_state         <= S_DONE;
                        end else begin
                            r_state         <= S_DRAIN;
                        end
                    end else begin
                        r_beat <= r_beat + 1'b1;
                        // Row address wraps silently at the top of the address space.
                        r_addr <= r_addr + 1'b1;
                    end
                end

                S_DRAIN: begin
                    // Once no return is in flight, the last rvalid is on the outputs now.
                    if (!r_rd_pend) begin
                        r_done[r_owner] <= 1'b1;
                        r_state         <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_grant <= '0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign r0_grant  = r_grant[0];
    assign r1_grant  = r_grant[1];
    assign r0_wack   = r_wack[0];
    assign r1_wack   = r_wack[1];
    assign r0_rvalid = r_rvalid[0];
    assign r1_rvalid = r_rvalid[1];
    assign r0_done   = r_done[0];
    assign r1_done   = r_done[1];
    assign rd_data   = r_rd_data;
    assign tbm_cs    = r_cs;
    assign tbm_we    = r_we;
    assign tbm_addr  = r_addr;

endmodule

// File: tb/tb_tbm_port_arbiter.sv
// Testbench for tbm_port_arbiter.
// A small TBM row memory answers the DUT. A reference model predicts each
// burst from the arbitration rule and the latency formulas (grant window,
// chip-select window, address sequence, wack/rvalid windows, done cycle)
// and keeps its own copy of the row contents.
module tb_tbm_port_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 256;
    localparam int LEN_W    = 4;
    localparam int MEM_ROWS = 1024;

    logic              clock_fpga = 1'b0;
    logic              reset_n    = 1'b0;

    logic              r0_req   = 1'b0;
    logic              r0_write = 1'b0;
    logic [ADDR_W-1:0] r0_addr  = '0;
    logic [LEN_W-1:0]  r0_len   = '0;
    logic [DATA_W-1:0] r0_wdata = '0;
    logic              r1_req   = 1'b0;
    logic              r1_write = 1'b0;
    logic [ADDR_W-1:0] r1_addr  = '0;
    logic [LEN_W-1:0]  r1_len   = '0;
    logic [DATA_W-1:0] r1_wdata = '0;

    logic              r0_grant, r0_wack, r0_rvalid, r0_done;
    logic              r1_grant, r1_wack, r1_rvalid, r1_done;
    logic [DATA_W-1:0] rd_data;
    logic              tbm_cs, tbm_we;
    logic [ADDR_W-1:0] tbm_addr;
    wire  [DATA_W-1:0] tbm_data;

    always #5 clock_fpga = ~clock_fpga;

    tbm_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clock_fpga (clock_fpga),
        .reset_n    (reset_n),
        .r0_req     (r0_req),
        .r0_write   (r0_write),
        .r0_addr    (r0_addr),
        .r0_len     (r0_len),
        .r0_wdata   (r0_wdata),
        .r0_grant   (r0_grant),
        .r0_wack    (r0_wack),
        .r0_rvalid  (r0_rvalid),
        .r0_done    (r0_done),
        .r1_req     (r1_req),
        .r1_write   (r1_write),
        .r1_addr    (r1_addr),
        .r1_len     (r1_len),
        .r1_wdata   (r1_wdata),
        .r1_grant   (r1_grant),
        .r1_wack    (r1_wack),
        .r1_rvalid  (r1_rvalid),
        .r1_done    (r1_done),
        .rd_data    (rd_data),
        .tbm_cs     (tbm_cs),
        .tbm_we     (tbm_we),
        .tbm_addr   (tbm_addr),
        .tbm_data   (tbm_data)
    );

    // ------------------------------------------------------------------
    // TBM row memory: writes on cs&we, read row returned the cycle after cs.
    // Only the low 10 address bits select a row; the model aliases the same way.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] tbm_mem [MEM_ROWS] = '{default: '0};
    logic              tbm_rd_en  = 1'b0;
    logic [DATA_W-1:0] tbm_rd_row = '0;

    always @(posedge clock_fpga) begin
        if (tbm_cs && tbm_we) tbm_mem[tbm_addr[9:0]] <= tbm_data;
        tbm_rd_en  <= tbm_cs && !tbm_we;
        tbm_rd_row <= tbm_mem[tbm_addr[9:0]];
    end

    assign tbm_data = tbm_rd_en ? tbm_rd_row : {DATA_W{1'bz}};

    // ------------------------------------------------------------------
    // Reference model state and bookkeeping
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] ref_mem [MEM_ROWS] = '{default: '0};
    int                last_owner = 1;
    bit                p_write [2];
    logic [ADDR_W-1:0] p_addr  [2];
    logic [LEN_W-1:0]  p_len   [2];
    logic [DATA_W-1:0] pat     [2][16];
    int                n_pass  = 0;
    int                n_fail  = 0;
    int                n_total = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input int who);
        return (who == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic bit req_of(input int who);
        return (who == 0) ? r0_req : r1_req;
    endfunction

    task automatic step();
        @(posedge clock_fpga);
        #1;
    endtask

    task automatic set_req_line(input int who, input bit v);
        if (who == 0) r0_req = v;
        else          r1_req = v;
    endtask

    task automatic assert_req(input int who);
        if (who == 0) begin
            r0_write = p_write[0]; r0_addr = p_addr[0]; r0_len = p_len[0]; r0_req = 1'b1;
        end else begin
            r1_write = p_write[1]; r1_addr = p_addr[1]; r1_len = p_len[1]; r1_req = 1'b1;
        end
    endtask

    task automatic set_req(input int who, input bit wr, input logic [ADDR_W-1:0] a,
                           input logic [LEN_W-1:0] l, input bit idx_pat);
        p_write[who] = wr;
        p_addr[who]  = a;
        p_len[who]   = l;
        for (int b = 0; b < 16; b++) begin
            if (idx_pat) pat[who][b] = DATA_W'(b);
            else for (int q = 0; q < DATA_W / 32; q++) pat[who][b][q*32 +: 32] = $urandom;
        end
        assert_req(who);
    endtask

    task automatic drive_wdata(input int who, input logic [DATA_W-1:0] d);
        if (who == 0) r0_wdata = d;
        else          r1_wdata = d;
    endtask

    // Change request fields mid-burst; the owner's burst must not notice.
    task automatic scramble(input int who);
        if (who == 0) begin r0_addr = $urandom; r0_len = LEN_W'($urandom); end
        else          begin r1_addr = $urandom; r1_len = LEN_W'($urandom); end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"},  {r1_grant, r0_grant},   2'b00);
        check({tag, "_wack"},   {r1_wack, r0_wack},     2'b00);
        check({tag, "_rvalid"}, {r1_rvalid, r0_rvalid}, 2'b00);
        check({tag, "_done"},   {r1_done, r0_done},     2'b00);
        check({tag, "_cs"},     tbm_cs,   1'b0);
        check({tag, "_we"},     tbm_we,   1'b0);
        check({tag, "_addr"},   tbm_addr, '0);
        check({tag, "_rdata"},  rd_data,  '0);
    endtask

    // Idle cycles: nothing granted, no chip select, no done.
    task automatic idle_cycles(input int c);
        for (int i = 0; i < c; i++) begin
            step();
            check("idle_grant", {r1_grant, r0_grant}, 2'b00);
            check("idle_cs",    tbm_cs,               1'b0);
            check("idle_done",  {r1_done, r0_done},   2'b00);
        end
    endtask

    // One burst, starting in an IDLE cycle where the requests are sampled.
    // Winner, windows and data come from the model; abort_at>0 pulses reset at that cycle.
    task automatic run_burst(input bit rereq0, input bit rereq1, input bit glitch, input int abort_at);
        int                w, o, n, d, widx;
        bit                wr, last_wack, glitching, cs_e, rv_e;
        logic [ADDR_W-1:0] base, ea;
        if (r0_req && r1_req) w = (last_owner == 1) ? 0 : 1;
        else if (r0_req)      w = 0;
        else                  w = 1;
        o          = 1 - w;
        last_owner = w;
        wr         = p_write[w];
        base       = p_addr[w];
        n          = (p_len[w] == 0) ? 16 : int'(p_len[w]);
        d          = wr ? 1 + n : 3 + n;
        widx       = 0;
        last_wack  = 1'b0;
        glitching  = glitch && !req_of(o);
        drive_wdata(w, pat[w][0]);
        for (int k = 1; k <= d; k++) begin
            @(posedge clock_fpga);
            #1;
            if (last_wack && widx < 15) widx++;
            drive_wdata(w, pat[w][widx]);
            if (k == abort_at) begin
                reset_n = 1'b0;
                #1;
                check_reset_outputs("rst_mid");
                r0_req = 1'b0;
                r1_req = 1'b0;
                step();
                check("rst_hold_done", {r1_done, r0_done}, 2'b00);
                reset_n = 1'b1;
                step();
                check("rst_post_grant", {r1_grant, r0_grant}, 2'b00);
                check("rst_post_done",  {r1_done, r0_done},   2'b00);
                check("rst_post_cs",    tbm_cs,               1'b0);
                last_owner = 1;
                if (wr) for (int b = 0; b < k - 1; b++) begin
                    ea = base + ADDR_W'(b);
                    ref_mem[ea[9:0]] = pat[w][b];
                end
                return;
            end
            #1;
            cs_e = (k <= n);
            rv_e = !wr && (k >= 3) && (k <= n + 2);
            ea   = base + ADDR_W'(k - 1);
            check("grant", {r1_grant, r0_grant}, onehot(w));
            check("cs", tbm_cs, cs_e);
            if (cs_e) begin
                check("we",   tbm_we,   wr);
                check("addr", tbm_addr, ea);
            end
            check("wack", {r1_wack, r0_wack}, (wr && cs_e) ? onehot(w) : 2'b00);
            if (wr && cs_e) check("wdata_bus", tbm_data, pat[w][k-1]);
            check("rvalid", {r1_rvalid, r0_rvalid}, rv_e ? onehot(w) : 2'b00);
            if (rv_e) begin
                ea = base + ADDR_W'(k - 3);
                check("rd_data", rd_data, ref_mem[ea[9:0]]);
            end
            check("done", {r1_done, r0_done}, (k == d) ? onehot(w) : 2'b00);
            last_wack = (w == 0) ? r0_wack : r1_wack;
            if (k == 1) set_req_line(w, 1'b0);
            if (k == 2) begin
                scramble(w);
                if (glitching) set_req_line(o, 1'b1);
            end
            if (glitching && (k == 3 || k == d)) set_req_line(o, 1'b0);
            if (k == d && ((w == 0) ? rereq0 : rereq1)) assert_req(w);
        end
        if (wr) for (int b = 0; b < n; b++) begin
            ea = base + ADDR_W'(b);
            ref_mem[ea[9:0]] = pat[w][b];
        end
    endtask

    // ------------------------------------------------------------------
    // Directed sequence followed by randomized bursts
    // ------------------------------------------------------------------
    initial begin
        int guard;
        // Reset state
        reset_n = 1'b0;
        step();
        step();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        step();
        idle_cycles(2);

        // r0 write 0x100, len 4, data = beat index
        set_req(0, 1'b1, 32'h0000_0100, 4'd4, 1'b1);
        run_burst(1'b0, 1'b0, 1'b0, 0);
        idle_cycles(1);

        // Tie right after a fresh reset: r0 first, then r1 reading 0x100..0x103
        reset_n = 1'b0;
        #1;
        check_reset_outputs("reset2");
        step();
        reset_n = 1'b1;
        step();
        last_owner = 1;
        set_req(0, 1'b1, 32'h0000_0200, 4'd3, 1'b0);
        set_req(1, 1'b0, 32'h0000_0100, 4'd4, 1'b0);
        run_burst(1'b0, 1'b0, 1'b0, 0);
        idle_cycles(1);
        run_burst(1'b0, 1'b0, 1'b0, 0);
        idle_cycles(1);

        // Maximum burst with address wrap, written by r1 and read back by r0
        set_req(1, 1'b1, 32'hFFFF_FFF8, 4'd0, 1'b0);
        run_burst(1'b0, 1'b0, 1'b0, 0);
        idle_cycles(1);
        set_req(0, 1'b0, 32'hFFFF_FFF8, 4'd0, 1'b0);
        run_burst(1'b0, 1'b0, 1'b0, 0);
        idle_cycles(1);

        // r1 solo read, leaving r1 as last owner
        set_req(1, 1'b0, 32'h0000_0200, 4'd3, 1'b0);
        run_burst(1'b0, 1'b0, 1'b0, 0);
        idle_cycles(1);

        // Fairness: r0 keeps re-requesting, r1 waits; grants go r0, r1, r0, r1
        set_req(0, 1'b1, 32'h0000_0240, 4'd2, 1'b0);
        set_req(1, 1'b0, 32'h0000_0240, 4'd2, 1'b0);
        run_burst(1'b1, 1'b0, 1'b0, 0);
        idle_cycles(1);
        run_burst(1'b1, 1'b0, 1'b0, 0);
        idle_cycles(1);
        assert_req(1);
        run_burst(1'b0, 1'b0, 1'b0, 0);
        idle_cycles(1);
        run_burst(1'b0, 1'b0, 1'b0, 0);
        idle_cycles(1);

        // r1 request dropped before it could be granted is never served
        set_req(0, 1'b1, 32'h0000_0280, 4'd5, 1'b0);
        run_burst(1'b0, 1'b0, 1'b1, 0);
        idle_cycles(4);

        // Reset during beat 2 of an 8-beat write, then a fresh read of the same rows
        set_req(0, 1'b1, 32'h0000_0300, 4'd8, 1'b0);
        run_burst(1'b0, 1'b0, 1'b0, 3);
        set_req(0, 1'b0, 32'h0000_0300, 4'd8, 1'b0);
        run_burst(1'b0, 1'b0, 1'b0, 0);
        idle_cycles(1);

        // Randomized traffic from one or both requesters
        for (int it = 0; it < 12; it++) begin
            int mask;
            mask = int'($urandom_range(1, 3));
            for (int who = 0; who < 2; who++) begin
                if (mask[who]) begin
                    set_req(who, 1'($urandom_range(0, 1)),
                            ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom) : ADDR_W'(32'h400 + $urandom_range(0, 63)),
                            LEN_W'($urandom), 1'b0);
                end
            end
            guard = 0;
            while ((r0_req || r1_req) && guard < 4) begin
                run_burst(1'b0, 1'b0, 1'b0, 0);
                idle_cycles(1);
                guard++;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
